// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath and its front end.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 8;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_AND   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_XOR   = 4'd4;
  localparam op_t OP_NOTA  = 4'd5;
  localparam op_t OP_NOTB  = 4'd6;
  localparam op_t OP_PASSA = 4'd7;
  localparam op_t OP_PASSB = 4'd8;
  localparam op_t OP_SHL   = 4'd9;
  localparam op_t OP_SHR   = 4'd10;
  localparam op_t OP_INC   = 4'd11;
  localparam op_t OP_DEC   = 4'd12;

  // Result flags travelling with each response.
  typedef struct packed {
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu.sv
// Shared 8-bit ALU: purely combinational result, no flags.
module alu
  import alu_pkg::*;
(
  input  op_t   op_i,
  input  data_t a_i,
  input  data_t b_i,
  output data_t r_o
);

  // Opcode decode; unused opcodes produce zero.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    r_o = '0;
    case (op_i)
      OP_ADD:   r_o = a_i + b_i;
      OP_SUB:   r_o = a_i - b_i;
      OP_AND:   r_o = a_i & b_i;
      OP_OR:    r_o = a_i | b_i;
      OP_XOR:   r_o = a_i ^ b_i;
      OP_NOTA:  r_o = ~a_i;
      OP_NOTB:  r_o = ~b_i;
      OP_PASSA: r_o = a_i;
      OP_PASSB: r_o = b_i;
      OP_SHL:   r_o = a_i << 1;
      OP_SHR:   r_o = a_i >> 1;
      OP_INC:   r_o = a_i + 8'd1;
      OP_DEC:   r_o = a_i - 8'd1;
      default:  r_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbitrated front end for the shared ALU: operand stage (S1),
// result stage (S2), single tagged valid/ready response port.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  req0_valid_i,
  output logic  req0_ready_o,
  input  op_t   req0_op_i,
  input  data_t req0_a_i,
  input  data_t req0_b_i,
  input  logic  req1_valid_i,
  output logic  req1_ready_o,
  input  op_t   req1_op_i,
  input  data_t req1_a_i,
  input  data_t req1_b_i,
  output logic  rsp_valid_o,
  input  logic  rsp_ready_i,
  output logic  rsp_id_o,
  output data_t rsp_r_o,
  output logic  rsp_z_o,
  output logic  rsp_c_o,
  output logic  busy_o
);

  // S1: operand register
  logic   s1_valid_q;
  op_t    s1_op_q;
  data_t  s1_a_q, s1_b_q;
  logic   s1_id_q;
  // S2: result register
  logic   s2_valid_q;
  data_t  s2_r_q;
  flags_t s2_flags_q;
  logic   s2_id_q;
  // Port that won the most recent accepted handshake
  logic   last_id_q;

  logic   s1_adv, s2_adv;
  logic   grant_id, accept;
  data_t  alu_r;
  flags_t flags_d;
  logic [DATA_W:0] sum9;

  assign s2_adv = !s2_valid_q || rsp_ready_i;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Pick a port: round-robin against last_id, or port 0 first when not fair.
  always_comb begin
    grant_id = 1'b0;
    if (FAIR) begin
      if (req0_valid_i && req1_valid_i) grant_id = ~last_id_q;
      else                               grant_id = req1_valid_i && !req0_valid_i;
    end else begin
      grant_id = !req0_valid_i;
    end
  end

  // Ready is forced low during reset so nothing is accepted on a reset edge.
  assign req0_ready_o = rst_ni && s1_adv && (grant_id == 1'b0) && req0_valid_i;
  assign req1_ready_o = rst_ni && s1_adv && (grant_id == 1'b1) && req1_valid_i;
  assign accept       = req0_ready_o || req1_ready_o;

  alu u_alu (
    .op_i (s1_op_q),
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .r_o  (alu_r)
  );

  assign sum9 = {1'b0, s1_a_q} + {1'b0, s1_b_q};

  // Carry/borrow/shift-out and zero flag for the operation held in S1.
  always_comb begin
    flags_d.z = (alu_r == '0);
    flags_d.c = 1'b0;
    case (s1_op_q)
      OP_ADD:  flags_d.c = sum9[DATA_W];
      OP_SUB:  flags_d.c = (s1_a_q < s1_b_q);
      OP_SHL:  flags_d.c = s1_a_q[DATA_W-1];
      OP_SHR:  flags_d.c = s1_a_q[0];
      OP_INC:  flags_d.c = (s1_a_q == 8'hFF);
      OP_DEC:  flags_d.c = (s1_a_q == 8'h00);
      default: flags_d.c = 1'b0;
    endcase
  end

  // Pipeline registers and arbitration history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: data registers are reset too because they drive the response outputs directly.
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_flags_q <= '0;
      s2_id_q    <= 1'b0;
      last_id_q  <= 1'b1;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_r_q     <= alu_r;
          s2_flags_q <= flags_d;
          s2_id_q    <= s1_id_q;
        end
      end
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_op_q   <= grant_id ? req1_op_i : req0_op_i;
          s1_a_q    <= grant_id ? req1_a_i  : req0_a_i;
          s1_b_q    <= grant_id ? req1_b_i  : req0_b_i;
          s1_id_q   <= grant_id;
          last_id_q <= grant_id;
        end
      end
    end
  end

  assign rsp_valid_o = s2_valid_q;
  assign rsp_id_o    = s2_id_q;
  assign rsp_r_o     = s2_r_q;
  assign rsp_z_o     = s2_flags_q.z;
  assign rsp_c_o     = s2_flags_q.c;
  assign busy_o      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority
// instance share the stimulus; each test observes the instance it targets.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  logic req0_valid, req1_valid, rsp_ready;
  op_t  req0_op, req1_op;
  data_t req0_a, req0_b, req1_a, req1_b;

  logic  rr_rdy0, rr_rdy1, rr_rsp_valid, rr_rsp_id, rr_rsp_z, rr_rsp_c, rr_busy;
  data_t rr_rsp_r;
  logic  fp_rdy0, fp_rdy1, fp_rsp_valid, fp_rsp_id, fp_rsp_z, fp_rsp_c, fp_busy;
  data_t fp_rsp_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FAIR(1'b1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid), .req0_ready_o(rr_rdy0), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(rr_rdy1), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp_valid_o(rr_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rr_rsp_id),
    .rsp_r_o(rr_rsp_r), .rsp_z_o(rr_rsp_z), .rsp_c_o(rr_rsp_c), .busy_o(rr_busy)
  );

  alu_arbiter #(.FAIR(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid), .req0_ready_o(fp_rdy0), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(fp_rdy1), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp_valid_o(fp_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(fp_rsp_id),
    .rsp_r_o(fp_rsp_r), .rsp_z_o(fp_rsp_z), .rsp_c_o(fp_rsp_c), .busy_o(fp_busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_ni = 1'b0;
    idle_inputs();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic check_rsp(input string tag, input logic id, input data_t r,
                           input logic z, input logic c);
    check({tag, ".valid"}, 16'(rr_rsp_valid), 16'd1);
    check({tag, ".id"},    16'(rr_rsp_id),    16'(id));
    check({tag, ".r"},     16'(rr_rsp_r),     16'(r));
    check({tag, ".z"},     16'(rr_rsp_z),     16'(z));
    check({tag, ".c"},     16'(rr_rsp_c),     16'(c));
  endtask

  // One isolated command through the round-robin instance, checking latency and result.
  task automatic run_one(input string tag, input logic id, input op_t op, input data_t a,
                         input data_t b, input data_t exp_r, input logic exp_z, input logic exp_c);
    int n;
    step();
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    n = 0;
    while (!(id ? rr_rdy1 : rr_rdy0) && n < 10) begin
      step();
      #1;
      n++;
    end
    check({tag, ".rdy"}, 16'(id ? rr_rdy1 : rr_rdy0), 16'd1);
    step();
    idle_inputs();
    #1;
    check({tag, ".lat1"}, 16'(rr_rsp_valid), 16'd0);
    step();
    #1;
    check_rsp(tag, id, exp_r, exp_z, exp_c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    // Both ports request during reset: nothing may be granted.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst.rr_rdy0", 16'(rr_rdy0), 16'd0);
      check("rst.rr_rdy1", 16'(rr_rdy1), 16'd0);
      check("rst.fp_rdy0", 16'(fp_rdy0), 16'd0);
      check("rst.fp_rdy1", 16'(fp_rdy1), 16'd0);
      step();
      #1;
    end
    idle_inputs();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #1;
    check("idle.valid", 16'(rr_rsp_valid), 16'd0);
    check("idle.id",    16'(rr_rsp_id),    16'd0);
    check("idle.r",     16'(rr_rsp_r),     16'd0);
    check("idle.z",     16'(rr_rsp_z),     16'd0);
    check("idle.c",     16'(rr_rsp_c),     16'd0);
    check("idle.busy",  16'(rr_busy),      16'd0);
    check("idle.fbusy", 16'(fp_busy),      16'd0);

    // Single-command vectors, including wrap-around boundaries.
    run_one("add_wrap", 1'b0, OP_ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run_one("add_7f",   1'b0, OP_ADD,   8'h7F, 8'h01, 8'h80, 1'b0, 1'b0);
    run_one("sub_wrap", 1'b1, OP_SUB,   8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
    run_one("inc_ff",   1'b0, OP_INC,   8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
    run_one("dec_00",   1'b1, OP_DEC,   8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
    run_one("shl_81",   1'b0, OP_SHL,   8'h81, 8'h00, 8'h02, 1'b0, 1'b1);
    run_one("shr_02",   1'b1, OP_SHR,   8'h02, 8'h00, 8'h01, 1'b0, 1'b0);
    run_one("notb_ff",  1'b0, OP_NOTB,  8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_one("passb",    1'b1, OP_PASSB, 8'h11, 8'hA5, 8'hA5, 1'b0, 1'b0);
    run_one("and_zero", 1'b0, OP_AND,   8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0);
    run_one("op13",     1'b1, 4'd13,    8'h12, 8'h34, 8'h00, 1'b1, 1'b0);

    // Round-robin with both ports continuously valid: grants 0,1,0,1.
    do_reset();
    rsp_ready = 1'b1;
    req0_op = OP_SUB; req0_a = 8'h05; req0_b = 8'h07;
    req1_op = OP_SHR; req1_a = 8'h03; req1_b = 8'h00;
    for (int k = 0; k < 6; k++) begin
      step();
      req0_valid = (k < 4);
      req1_valid = (k < 4);
      #1;
      check("rr.rdy0", 16'(rr_rdy0), 16'(k < 4 && k % 2 == 0));
      check("rr.rdy1", 16'(rr_rdy1), 16'(k < 4 && k % 2 == 1));
      if (k >= 2) begin
        if (k % 2 == 0) check_rsp("rr.sub", 1'b0, 8'hFE, 1'b0, 1'b1);
        else            check_rsp("rr.shr", 1'b1, 8'h01, 1'b0, 1'b1);
      end
    end

    // Fixed priority: port 1 waits until port 0 drops valid.
    do_reset();
    rsp_ready = 1'b1;
    req0_op = OP_AND; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_op = OP_OR;  req1_a = 8'h0F; req1_b = 8'h30;
    for (int k = 0; k < 6; k++) begin
      step();
      req0_valid = (k < 3);
      req1_valid = (k < 5);
      #1;
      check("fp.rdy0", 16'(fp_rdy0), 16'(k < 3));
      check("fp.rdy1", 16'(fp_rdy1), 16'(k >= 3 && k < 5));
      if (k == 2) begin
        check("fp.p0.valid", 16'(fp_rsp_valid), 16'd1);
        check("fp.p0.id",    16'(fp_rsp_id),    16'd0);
        check("fp.p0.r",     16'(fp_rsp_r),     16'h30);
      end
      if (k == 5) begin
        check("fp.p1.valid", 16'(fp_rsp_valid), 16'd1);
        check("fp.p1.id",    16'(fp_rsp_id),    16'd1);
        check("fp.p1.r",     16'(fp_rsp_r),     16'h3F);
      end
    end
    idle_inputs();

    // Backpressure: two commands fill the pipe, the third waits.
    do_reset();
    rsp_ready = 1'b0;
    step();
    req0_valid = 1'b1; req0_op = OP_XOR; req0_a = 8'h0F; req0_b = 8'hFF;
    #1;
    check("bp.rdyA", 16'(rr_rdy0), 16'd1);
    step();
    req0_op = OP_INC; req0_a = 8'hFF; req0_b = 8'h00;
    #1;
    check("bp.rdyB", 16'(rr_rdy0), 16'd1);
    check("bp.novalid", 16'(rr_rsp_valid), 16'd0);
    for (int k = 2; k < 6; k++) begin
      step();
      req0_op = OP_DEC; req0_a = 8'h00; req0_b = 8'h00;
      #1;
      check("bp.rdyC_low", 16'(rr_rdy0), 16'd0);
      check_rsp("bp.holdA", 1'b0, 8'hF0, 1'b0, 1'b0);
    end
    step();
    rsp_ready = 1'b1;
    #1;
    check("bp.rdyC", 16'(rr_rdy0), 16'd1);
    check_rsp("bp.A", 1'b0, 8'hF0, 1'b0, 1'b0);
    step();
    idle_inputs();
    #1;
    check_rsp("bp.B", 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    #1;
    check_rsp("bp.C", 1'b0, 8'hFF, 1'b0, 1'b1);
    step();
    #1;
    check("bp.empty", 16'(rr_rsp_valid), 16'd0);
    check("bp.busy",  16'(rr_busy),      16'd0);

    // Reset with both stages full discards everything.
    rsp_ready = 1'b0;
    step();
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 8'h01; req1_b = 8'h01;
    #1;
    check("mid.rdy1a", 16'(rr_rdy1), 16'd1);
    step();
    req1_op = OP_SUB; req1_a = 8'h09; req1_b = 8'h03;
    #1;
    check("mid.rdy1b", 16'(rr_rdy1), 16'd1);
    step();
    idle_inputs();
    #1;
    check("mid.full_busy",  16'(rr_busy),      16'd1);
    check("mid.full_valid", 16'(rr_rsp_valid), 16'd1);
    check("mid.full_r",     16'(rr_rsp_r),     16'h02);
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("mid.valid", 16'(rr_rsp_valid), 16'd0);
    check("mid.busy",  16'(rr_busy),      16'd0);
    step();
    #1;
    check("mid.valid2", 16'(rr_rsp_valid), 16'd0);
    run_one("op14", 1'b0, 4'd14, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
